// File: rtl/variable_delay_line_if.sv
// variable_delay_line_if
//   Bundles the sample stream, flow-control and delay-configuration signals
//   of variable_delay_line.
//   master : upstream/controller side (drives samples, STALL, FLUSH, config)
//   slave  : the delay line itself
//   Signals:
//     IN_VALID/IN_DATA/IN_READY  input sample handshake
//     STALL, FLUSH               pipeline freeze / discard
//     CFG_WE/CFG_DELAY/CFG_BUSY  delay change request and pending flag
//     CUR_DELAY, OCCUPANCY       delay in effect, samples inside the tap window
//     OUT_VALID/OUT_DATA         delayed sample (data zero when not valid)
`timescale 1ns/1ps
interface variable_delay_line_if #(
    parameter int WIDTH   = 8,
    parameter int DEPTH_W = 5
);
    logic               IN_VALID;
    logic [WIDTH-1:0]   IN_DATA;
    logic               IN_READY;
    logic               STALL;
    logic               FLUSH;
    logic               CFG_WE;
    logic [DEPTH_W-1:0] CFG_DELAY;
    logic               CFG_BUSY;
    logic [DEPTH_W-1:0] CUR_DELAY;
    logic               OUT_VALID;
    logic [WIDTH-1:0]   OUT_DATA;
    logic [DEPTH_W-1:0] OCCUPANCY;

    modport master (
        output IN_VALID, IN_DATA, STALL, FLUSH, CFG_WE, CFG_DELAY,
        input  IN_READY, CFG_BUSY, CUR_DELAY, OUT_VALID, OUT_DATA, OCCUPANCY
    );

    modport slave (
        input  IN_VALID, IN_DATA, STALL, FLUSH, CFG_WE, CFG_DELAY,
        output IN_READY, CFG_BUSY, CUR_DELAY, OUT_VALID, OUT_DATA, OCCUPANCY
    );
endinterface

// File: rtl/variable_delay_line.sv
// variable_delay_line
//   Multi-channel delay line: WIDTH-bit samples with a valid flag move through
//   MAX_DEPTH register stages; the output is tapped at stage CUR_DELAY-1.
//   A new delay is only applied once the tap window is empty, so in-flight
//   samples always leave at the delay they entered with.
//   Ports:
//     CLK    rising-edge clock
//     RESET  synchronous, active-high reset
//     bus    variable_delay_line_if.slave (samples, STALL/FLUSH, config, status)
`timescale 1ns/1ps
module variable_delay_line #(
    parameter int WIDTH         = 8,
    parameter int MAX_DEPTH     = 16,
    parameter int DEPTH_W       = 5,
    parameter int DEFAULT_DELAY = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    variable_delay_line_if.slave     bus
);

    localparam logic [DEPTH_W-1:0] MAX_D   = DEPTH_W'(MAX_DEPTH);
    localparam int                 DEF_INT = (DEFAULT_DELAY < 1) ? 1 :
                                             (DEFAULT_DELAY > MAX_DEPTH) ? MAX_DEPTH :
                                             DEFAULT_DELAY;
    localparam logic [DEPTH_W-1:0] DEF_D   = DEPTH_W'(DEF_INT);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t             state, next_state;
    logic               stage_valid [MAX_DEPTH];
    logic [WIDTH-1:0]   stage_data  [MAX_DEPTH];
    logic [DEPTH_W-1:0] cur_delay;
    logic [DEPTH_W-1:0] pending;
    logic [DEPTH_W-1:0] occupancy;
    logic               in_ready;
    logic               accept;
    logic               tap_valid;
    logic [WIDTH-1:0]   tap_data;
    logic [DEPTH_W-1:0] cfg_clamped;
    logic               apply_delay;
    logic [DEPTH_W-1:0] new_delay;
    logic [DEPTH_W-1:0] flush_delay;

    function automatic logic [DEPTH_W-1:0] clamp_delay(input logic [DEPTH_W-1:0] d);
        if (d == '0)
            return DEPTH_W'(1);
        else if (d > MAX_D)
            return MAX_D;
        else
            return d;
    endfunction

    assign cfg_clamped = clamp_delay(bus.CFG_DELAY);
    assign accept      = bus.IN_VALID && in_ready;

    // A config write in the apply cycle is the latest request, so it beats PENDING.
    assign new_delay   = bus.CFG_WE ? cfg_clamped : pending;

    // Flush: direct config write first, then any pending change, else keep.
    assign flush_delay = bus.CFG_WE         ? cfg_clamped :
                         (state == DRAIN)   ? pending     :
                                              cur_delay;

    // State register
    always_ff @(posedge CLK) begin
        if (RESET)
            state <= RUN;
        else
            state <= next_state;
    end

    // Next-state logic; apply_delay marks the edge on which CUR_DELAY changes
    // outside of a flush.
    always_comb begin
        next_state  = state;
        apply_delay = 1'b0;
        case (state)
            RUN: begin
                if (bus.CFG_WE) begin
                    if (occupancy == '0 && !accept)
                        apply_delay = 1'b1;
                    else
                        next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (occupancy == '0) begin
                    apply_delay = 1'b1;
                    next_state  = RUN;
                end
            end
            default: next_state = RUN;
        endcase
        if (bus.FLUSH)
            next_state = RUN;
    end

    // Output logic of the controller
    always_comb begin
        in_ready     = (state == RUN) && !bus.STALL && !bus.FLUSH;
        bus.CFG_BUSY = (state == DRAIN);
    end

    assign bus.IN_READY = in_ready;

    // Output tap: compare against each legal delay so the select never
    // indexes past the stage array.
    always_comb begin
        tap_valid = 1'b0;
        tap_data  = '0;
        for (int k = 0; k < MAX_DEPTH; k++) begin
            if (cur_delay == DEPTH_W'(k + 1)) begin
                tap_valid = stage_valid[k];
                tap_data  = stage_data[k];
            end
        end
    end

    // Stages whose valid bit was cleared by a delay change may still hold
    // old data, so the output data is masked by valid.
    assign bus.OUT_VALID = tap_valid;
    assign bus.OUT_DATA  = tap_valid ? tap_data : '0;
    assign bus.CUR_DELAY = cur_delay;
    assign bus.OCCUPANCY = occupancy;

    // Datapath: stage shift, occupancy tracking and delay registers.
    always_ff @(posedge CLK) begin
        if (RESET || bus.FLUSH) begin
            for (int k = 0; k < MAX_DEPTH; k++) begin
                stage_valid[k] <= 1'b0;
                stage_data[k]  <= '0;
            end
            occupancy <= '0;
            if (RESET) begin
                cur_delay <= DEF_D;
                pending   <= DEF_D;
            end else begin
                cur_delay <= flush_delay;
            end
        end else begin
            if (!bus.STALL) begin
                stage_valid[0] <= accept;
                stage_data[0]  <= accept ? bus.IN_DATA : '0;
                for (int k = 1; k < MAX_DEPTH; k++) begin
                    stage_valid[k] <= stage_valid[k-1];
                    stage_data[k]  <= stage_data[k-1];
                end
                case ({accept, tap_valid})
                    2'b10:   occupancy <= occupancy + DEPTH_W'(1);
                    2'b01:   occupancy <= occupancy - DEPTH_W'(1);
                    default: occupancy <= occupancy;
                endcase
            end
            if (bus.CFG_WE)
                pending <= cfg_clamped;
            // Applying a new delay drops everything, including stale entries
            // beyond the old tap that would otherwise surface at a longer delay.
            if (apply_delay) begin
                cur_delay <= new_delay;
                occupancy <= '0;
                for (int k = 0; k < MAX_DEPTH; k++)
                    stage_valid[k] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_variable_delay_line.sv
// tb_variable_delay_line
//   Directed self-checking bench for variable_delay_line (WIDTH=8,
//   MAX_DEPTH=16, DEPTH_W=5, DEFAULT_DELAY=4). Inputs change 1 ns after the
//   rising edge; outputs are checked there as well, away from the edge.
`timescale 1ns/1ps
module tb_variable_delay_line;

    logic CLK = 1'b0;
    logic RESET;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    variable_delay_line_if #(.WIDTH(8), .DEPTH_W(5)) bus ();

    variable_delay_line #(
        .WIDTH(8),
        .MAX_DEPTH(16),
        .DEPTH_W(5),
        .DEFAULT_DELAY(4)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus)
    );

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic st,
                                 input logic fl, input logic we, input logic [4:0] cd);
        bus.IN_VALID  = v;
        bus.IN_DATA   = d;
        bus.STALL     = st;
        bus.FLUSH     = fl;
        bus.CFG_WE    = we;
        bus.CFG_DELAY = cd;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        // Reset
        RESET = 1'b1;
        applyStimulus(0, 8'h00, 0, 0, 0, 5'd0);
        tick();
        tick();
        RESET = 1'b0;
        #1;
        checkOutput("rst_out_valid", 32'(bus.OUT_VALID), 0);
        checkOutput("rst_out_data",  32'(bus.OUT_DATA), 0);
        checkOutput("rst_occupancy", 32'(bus.OCCUPANCY), 0);
        checkOutput("rst_cfg_busy",  32'(bus.CFG_BUSY), 0);
        checkOutput("rst_cur_delay", 32'(bus.CUR_DELAY), 4);
        checkOutput("rst_in_ready",  32'(bus.IN_READY), 1);

        // Default delay 4: three samples back to back
        applyStimulus(1, 8'h11, 0, 0, 0, 5'd0);
        tick();
        applyStimulus(1, 8'h22, 0, 0, 0, 5'd0);
        tick();
        applyStimulus(1, 8'h33, 0, 0, 0, 5'd0);
        tick();
        checkOutput("a_occ_peak",  32'(bus.OCCUPANCY), 3);
        checkOutput("a_not_early", 32'(bus.OUT_VALID), 0);
        applyStimulus(0, 8'h00, 0, 0, 0, 5'd0);
        tick();
        checkOutput("a_out1_valid", 32'(bus.OUT_VALID), 1);
        checkOutput("a_out1_data",  32'(bus.OUT_DATA), 32'h11);
        checkOutput("a_out1_occ",   32'(bus.OCCUPANCY), 3);
        tick();
        checkOutput("a_out2_data",  32'(bus.OUT_DATA), 32'h22);
        checkOutput("a_out2_occ",   32'(bus.OCCUPANCY), 2);
        tick();
        checkOutput("a_out3_data",  32'(bus.OUT_DATA), 32'h33);
        checkOutput("a_out3_occ",   32'(bus.OCCUPANCY), 1);
        tick();
        checkOutput("a_end_valid",  32'(bus.OUT_VALID), 0);
        checkOutput("a_end_occ",    32'(bus.OCCUPANCY), 0);

        // Stall: delay 3, two stall cycles mid-flight
        applyStimulus(0, 8'h00, 0, 0, 1, 5'd3);
        tick();
        applyStimulus(0, 8'h00, 0, 0, 0, 5'd0);
        checkOutput("b_cur_delay", 32'(bus.CUR_DELAY), 3);
        checkOutput("b_busy",      32'(bus.CFG_BUSY), 0);
        applyStimulus(1, 8'hA5, 0, 0, 0, 5'd0);
        tick();
        applyStimulus(0, 8'h00, 0, 0, 0, 5'd0);
        tick();
        applyStimulus(1, 8'hEE, 1, 0, 0, 5'd0);
        checkOutput("b_stall_ready", 32'(bus.IN_READY), 0);
        tick();
        checkOutput("b_stall1_valid", 32'(bus.OUT_VALID), 0);
        checkOutput("b_stall1_occ",   32'(bus.OCCUPANCY), 1);
        tick();
        checkOutput("b_stall2_occ",   32'(bus.OCCUPANCY), 1);
        applyStimulus(0, 8'h00, 0, 0, 0, 5'd0);
        checkOutput("b_unstall_ready", 32'(bus.IN_READY), 1);
        tick();
        checkOutput("b_out_valid", 32'(bus.OUT_VALID), 1);
        checkOutput("b_out_data",  32'(bus.OUT_DATA), 32'hA5);
        tick();
        checkOutput("b_after_valid", 32'(bus.OUT_VALID), 0);
        checkOutput("b_after_occ",   32'(bus.OCCUPANCY), 0);

        // Delay change 4 -> 2 with two samples in flight
        applyStimulus(0, 8'h00, 0, 0, 1, 5'd4);
        tick();
        applyStimulus(1, 8'h61, 0, 0, 0, 5'd0);
        tick();
        applyStimulus(1, 8'h62, 0, 0, 0, 5'd0);
        tick();
        applyStimulus(0, 8'h00, 0, 0, 1, 5'd2);
        tick();
        applyStimulus(1, 8'h99, 0, 0, 0, 5'd0);
        checkOutput("c_busy",      32'(bus.CFG_BUSY), 1);
        checkOutput("c_ready",     32'(bus.IN_READY), 0);
        checkOutput("c_old_delay", 32'(bus.CUR_DELAY), 4);
        tick();
        checkOutput("c_out1_data", 32'(bus.OUT_DATA), 32'h61);
        checkOutput("c_out1_busy", 32'(bus.CFG_BUSY), 1);
        tick();
        checkOutput("c_out2_data", 32'(bus.OUT_DATA), 32'h62);
        checkOutput("c_out2_occ",  32'(bus.OCCUPANCY), 1);
        tick();
        checkOutput("c_drained_valid", 32'(bus.OUT_VALID), 0);
        checkOutput("c_drained_occ",   32'(bus.OCCUPANCY), 0);
        checkOutput("c_drained_busy",  32'(bus.CFG_BUSY), 1);
        applyStimulus(0, 8'h00, 0, 0, 0, 5'd0);
        tick();
        checkOutput("c_new_delay", 32'(bus.CUR_DELAY), 2);
        checkOutput("c_idle_busy", 32'(bus.CFG_BUSY), 0);
        applyStimulus(1, 8'h77, 0, 0, 0, 5'd0);
        checkOutput("c_ready_again", 32'(bus.IN_READY), 1);
        tick();
        applyStimulus(0, 8'h00, 0, 0, 0, 5'd0);
        checkOutput("c_lat2_early", 32'(bus.OUT_VALID), 0);
        tick();
        checkOutput("c_lat2_valid", 32'(bus.OUT_VALID), 1);
        checkOutput("c_lat2_data",  32'(bus.OUT_DATA), 32'h77);
        tick();
        checkOutput("c_end_occ", 32'(bus.OCCUPANCY), 0);

        // Clamping: 0 -> 1, 31 -> 16, then latency 16
        applyStimulus(0, 8'h00, 0, 0, 1, 5'd0);
        tick();
        checkOutput("d_clamp_low", 32'(bus.CUR_DELAY), 1);
        applyStimulus(0, 8'h00, 0, 0, 1, 5'd31);
        tick();
        checkOutput("d_clamp_high", 32'(bus.CUR_DELAY), 16);
        applyStimulus(1, 8'hC3, 0, 0, 0, 5'd0);
        tick();
        applyStimulus(0, 8'h00, 0, 0, 0, 5'd0);
        for (int i = 0; i < 14; i++) begin
            tick();
            checkOutput("d_lat16_early", 32'(bus.OUT_VALID), 0);
        end
        tick();
        checkOutput("d_lat16_valid", 32'(bus.OUT_VALID), 1);
        checkOutput("d_lat16_data",  32'(bus.OUT_DATA), 32'hC3);
        tick();
        checkOutput("d_end_occ", 32'(bus.OCCUPANCY), 0);

        // Flush with a simultaneous config write
        applyStimulus(0, 8'h00, 0, 0, 1, 5'd4);
        tick();
        applyStimulus(1, 8'hA1, 0, 0, 0, 5'd0);
        tick();
        applyStimulus(1, 8'hA2, 0, 0, 0, 5'd0);
        tick();
        applyStimulus(1, 8'hA3, 0, 0, 0, 5'd0);
        tick();
        checkOutput("e_occ_before", 32'(bus.OCCUPANCY), 3);
        applyStimulus(0, 8'h00, 0, 1, 1, 5'd6);
        checkOutput("e_flush_ready", 32'(bus.IN_READY), 0);
        tick();
        applyStimulus(0, 8'h00, 0, 0, 0, 5'd0);
        checkOutput("e_out_valid", 32'(bus.OUT_VALID), 0);
        checkOutput("e_out_data",  32'(bus.OUT_DATA), 0);
        checkOutput("e_occ",       32'(bus.OCCUPANCY), 0);
        checkOutput("e_cur_delay", 32'(bus.CUR_DELAY), 6);
        checkOutput("e_busy",      32'(bus.CFG_BUSY), 0);
        checkOutput("e_ready",     32'(bus.IN_READY), 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput("e_no_ghost", 32'(bus.OUT_VALID), 0);
        end

        // DRAIN overwrite, then FLUSH during STALL applies the latest PENDING
        applyStimulus(1, 8'hD1, 0, 0, 0, 5'd0);
        tick();
        applyStimulus(0, 8'h00, 0, 0, 1, 5'd3);
        tick();
        checkOutput("g_busy1", 32'(bus.CFG_BUSY), 1);
        applyStimulus(0, 8'h00, 0, 0, 1, 5'd5);
        tick();
        checkOutput("g_busy2", 32'(bus.CFG_BUSY), 1);
        applyStimulus(0, 8'h00, 1, 1, 0, 5'd0);
        tick();
        applyStimulus(0, 8'h00, 0, 0, 0, 5'd0);
        checkOutput("g_cur_delay", 32'(bus.CUR_DELAY), 5);
        checkOutput("g_busy",      32'(bus.CFG_BUSY), 0);
        checkOutput("g_occ",       32'(bus.OCCUPANCY), 0);
        checkOutput("g_out_valid", 32'(bus.OUT_VALID), 0);

        // Reset in the middle of DRAIN discards PENDING
        applyStimulus(1, 8'hB1, 0, 0, 0, 5'd0);
        tick();
        applyStimulus(0, 8'h00, 0, 0, 1, 5'd8);
        tick();
        applyStimulus(0, 8'h00, 0, 0, 0, 5'd0);
        checkOutput("f_busy_before", 32'(bus.CFG_BUSY), 1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        #1;
        checkOutput("f_busy",      32'(bus.CFG_BUSY), 0);
        checkOutput("f_cur_delay", 32'(bus.CUR_DELAY), 4);
        checkOutput("f_out_valid", 32'(bus.OUT_VALID), 0);
        checkOutput("f_out_data",  32'(bus.OUT_DATA), 0);
        checkOutput("f_occ",       32'(bus.OCCUPANCY), 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("f_hold_delay", 32'(bus.CUR_DELAY), 4);
            checkOutput("f_no_sample",  32'(bus.OUT_VALID), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/variable_delay_line.md
Name: variable_delay_line

Overview:
Multi-channel, runtime-configurable delay line with valid tracking, stall and flush. It carries WIDTH-bit samples plus a valid flag through a MAX_DEPTH-stage register pipeline. Output is tapped at a programmable stage. Delay changes are applied only once the pipeline has drained, so no sample is duplicated or corrupted. It sits between acquisition front-ends and the processing core wherever channels must be time-aligned.

Parameters:
WIDTH, 8, data bits per sample (channel count)
MAX_DEPTH, 16, number of physical stages; maximum delay in cycles
DEPTH_W, 5, width of delay/occupancy fields; must satisfy 2^DEPTH_W > MAX_DEPTH
DEFAULT_DELAY, 4, delay loaded at reset (clamped as CFG_DELAY)

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  synchronous, active-high reset
IN_VALID  input  1  sample present on IN_DATA
IN_DATA  input  WIDTH  input sample
IN_READY  output  1  sample accepted this cycle when IN_VALID && IN_READY
STALL  input  1  freeze entire pipeline this cycle
FLUSH  input  1  discard all in-flight samples
CFG_WE  input  1  request new delay
CFG_DELAY  input  DEPTH_W  requested delay in cycles
CFG_BUSY  output  1  delay change pending (DRAIN state)
CUR_DELAY  output  DEPTH_W  delay currently in effect
OUT_VALID  output  1  OUT_DATA holds a delayed sample
OUT_DATA  output  WIDTH  delayed sample, zero when OUT_VALID=0
OCCUPANCY  output  DEPTH_W  valid samples within stages 0..CUR_DELAY-1

Behaviour:
- Reset is synchronous and active-high on CLK. All stage data and valid bits clear to 0. OUT_VALID=0, OUT_DATA=0, OCCUPANCY=0, CFG_BUSY=0, state=RUN. CUR_DELAY=clamp(DEFAULT_DELAY). Reset overrides every other input in the same cycle.
- Clamp rule: 0 maps to 1; values above MAX_DEPTH map to MAX_DEPTH; all other values pass unchanged.
- Pipeline: stages s[0..MAX_DEPTH-1], each holding {valid, data}.
  - On an advance cycle (STALL=0), s[0] gets {IN_VALID&&IN_READY, IN_DATA masked to 0 unless accepted}, and s[k] gets s[k-1].
  - On STALL=1, all stages, OCCUPANCY and outputs hold.
- Output: {OUT_VALID, OUT_DATA} = s[CUR_DELAY-1], a mux of registered stages with no extra register. A sample accepted at edge t appears at OUT after edge t+CUR_DELAY-1, i.e. latency is CUR_DELAY cycles, counting stall-free cycles only.
- IN_READY = (state==RUN) && !STALL && !FLUSH.
- OCCUPANCY on each advance cycle: +1 if a sample is accepted, -1 if OUT_VALID=1, unchanged if both. It never exceeds CUR_DELAY.
- States and transitions:
  - RUN: CFG_WE=1 with OCCUPANCY==0 and no accept this cycle: CUR_DELAY=clamp(CFG_DELAY) next cycle, all valid bits cleared, stay RUN.
  - RUN: CFG_WE=1 otherwise: latch PENDING=clamp(CFG_DELAY), go to DRAIN.
  - DRAIN: CFG_BUSY=1, no input accepted, pipeline keeps advancing (subject to STALL) so in-flight samples exit at the old delay. CFG_WE in DRAIN overwrites PENDING (last write wins).
  - DRAIN, once OCCUPANCY reaches 0: next edge sets CUR_DELAY=PENDING, clears all valid bits in stages 0..MAX_DEPTH-1 (removes stale entries beyond the old tap), returns to RUN.
- FLUSH, priority below RESET:
  - Clears all valid and data bits and sets OCCUPANCY=0 in one cycle; state becomes RUN.
  - Applies PENDING if in DRAIN.
  - With CFG_WE in the same cycle, clamp(CFG_DELAY) is applied directly and takes precedence over PENDING.
  - Asserting FLUSH during STALL still flushes.
- Simultaneous STALL and CFG_WE in RUN: the request is latched as above, with the same transitions; an immediate apply still occurs if OCCUPANCY==0.
- Samples are never reordered, duplicated or dropped except by FLUSH or RESET.

Test Plan:
- Reset, DEFAULT_DELAY=4: drive IN_VALID=1 with data 0x11,0x22,0x33 on consecutive cycles -> OUT_VALID rises exactly 4 cycles later, outputs 0x11,0x22,0x33 in order; OCCUPANCY peaks at 3.
- Stall: D=3, send 0xA5, assert STALL for 2 cycles mid-flight -> 0xA5 emerges 5 cycles after accept; OUT held and IN_READY=0 during stall.
- Delay change with data in flight: D=4, 2 samples in flight, CFG_WE with CFG_DELAY=2 -> CFG_BUSY=1 and IN_READY=0 until both exit at delay 4; CUR_DELAY=2 next cycle; the next sample has latency 2.
- Clamping: CFG_DELAY=0 on an empty pipe -> CUR_DELAY=1. CFG_DELAY=31 with MAX_DEPTH=16 -> CUR_DELAY=16; a sample then has latency 16.
- Flush: 3 samples in flight plus FLUSH together with CFG_WE=6 -> OUT_VALID=0 and OCCUPANCY=0 next cycle, CUR_DELAY=6, state RUN, none of the 3 samples appears.
- Reset mid-DRAIN: in DRAIN with PENDING=8, assert RESET -> CFG_BUSY=0, CUR_DELAY=4, all outputs 0, PENDING discarded.
